// File: rtl/cpu_step_controller_pkg.sv
// Shared definitions for the Mock8080 CPU/RAM execution strobe generator.
package cpu_step_controller_pkg;

    localparam int unsigned CNT_W_DEF      = 29;
    localparam int unsigned STEP_CNT_W_DEF = 16;
    localparam int unsigned MIN_PERIOD     = 2;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BREAK = 2'b10
    } run_state_e;

endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector; history resets high so a level held
// through reset release produces no edge.
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
            rise  <= 1'b0;
        end else begin
            btn_q <= btn;
            rise  <= btn & ~btn_q;
        end
    end

endmodule

// File: rtl/cpu_step_controller.sv
// Execution strobe for CPU/BRAM: single-step from a button or free-run at a
// programmable period, halting on HLT or on a PC breakpoint.
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned STEP_CNT_W = STEP_CNT_W_DEF
) (
    input  logic                  clk_qzt,
    input  logic                  reset_n,
    input  logic                  btn_step,
    input  logic                  btn_run,
    input  logic [CNT_W-1:0]      run_period,
    input  logic [7:0]            cpu_pc,
    input  logic                  cpu_halted,
    input  logic [7:0]            bp_addr,
    input  logic                  bp_en,
    output logic                  step_pulse,
    output logic                  running,
    output logic                  bp_hit,
    output logic [STEP_CNT_W-1:0] step_count
);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_eff;
    logic             skip_q, skip_d;
    logic             pulse_d;
    logic             step_edge, run_edge;
    logic             terminal, bp_match;

    rise_edge_detect u_step_edge (
        .clk   (clk_qzt),
        .rst_n (reset_n),
        .btn   (btn_step),
        .rise  (step_edge)
    );

    rise_edge_detect u_run_edge (
        .clk   (clk_qzt),
        .rst_n (reset_n),
        .btn   (btn_run),
        .rise  (run_edge)
    );

    // Periods below the minimum would strobe every cycle or never; clamp them.
    assign period_eff = (run_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : run_period;
    assign terminal   = (cnt_q == (period_eff - CNT_W'(1)));
    assign bp_match   = bp_en && (cpu_pc == bp_addr) && !skip_q;

    // Next-state: run edge first, then HLT, then period terminal / breakpoint.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (run_edge) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    skip_d  = 1'b1;
                end else if (step_edge) begin
                    pulse_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_edge || cpu_halted) begin
                    state_d = ST_HALT;
                end else if (terminal) begin
                    cnt_d = '0;
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        pulse_d = 1'b1;
                        skip_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (run_edge) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    skip_d  = 1'b1;
                end else if (step_edge) begin
                    pulse_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_HALT;
            cnt_q      <= '0;
            skip_q     <= 1'b0;
            step_pulse <= 1'b0;
            running    <= 1'b0;
            bp_hit     <= 1'b0;
            step_count <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            skip_q     <= skip_d;
            step_pulse <= pulse_d;
            running    <= (state_d == ST_RUN);
            bp_hit     <= (state_d == ST_BREAK);
            step_count <= step_count + STEP_CNT_W'(pulse_d);
        end
    end

endmodule
